ddr_axi_pattern_master: RTL

- AXI-style burst master that sits directly upstream of the DDR3 slave port and drives its write-address, write-data, write-response, read-address and read-data channels.
- On `start`, writes NUM_BURSTS INCR bursts of an address-derived pattern from BASE_ADDR, then reads the same region back and compares every beat.
- Reports completion, a sticky error flag and a saturating mismatch count; used for board bring-up and for simulation against the DDR3 model.

---
 rtl/ddr_axi_pattern_master_if.sv | 56 +++++
 rtl/ddr_axi_pattern_master.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_axi_pattern_master_if.sv
// AXI-style write/read channel bundle between the pattern master and the DDR3 slave port.
interface ddr_axi_pattern_master_if;
   logic [3:0]  M_WR_ADDR_ID;
   logic [31:0] M_WR_ADDR;
   logic [7:0]  M_WR_ADDR_LEN;
   logic [1:0]  M_WR_ADDR_BURST;
   logic        M_WR_ADDR_VALID;
   logic        M_WR_ADDR_READY;
   logic [31:0] M_WR_DATA;
   logic [3:0]  M_WR_STRB;
   logic        M_WR_DATA_LAST;
   logic        M_WR_DATA_VALID;
   logic        M_WR_DATA_READY;
   logic [3:0]  M_WR_BACK_ID;
   logic [1:0]  M_WR_BACK_RESP;
   logic        M_WR_BACK_VALID;
   logic        M_WR_BACK_READY;
   logic [3:0]  M_RD_ADDR_ID;
   logic [31:0] M_RD_ADDR;
   logic [7:0]  M_RD_ADDR_LEN;
   logic [1:0]  M_RD_ADDR_BURST;
   logic        M_RD_ADDR_VALID;
   logic        M_RD_ADDR_READY;
   logic [3:0]  M_RD_BACK_ID;
   logic [31:0] M_RD_DATA;
   logic [1:0]  M_RD_DATA_RESP;
   logic        M_RD_DATA_LAST;
   logic        M_RD_DATA_VALID;
   logic        M_RD_DATA_READY;

   modport master (
      output M_WR_ADDR_ID, M_WR_ADDR, M_WR_ADDR_LEN, M_WR_ADDR_BURST, M_WR_ADDR_VALID,
      input  M_WR_ADDR_READY,
      output M_WR_DATA, M_WR_STRB, M_WR_DATA_LAST, M_WR_DATA_VALID,
      input  M_WR_DATA_READY,
      input  M_WR_BACK_ID, M_WR_BACK_RESP, M_WR_BACK_VALID,
      output M_WR_BACK_READY,
      output M_RD_ADDR_ID, M_RD_ADDR, M_RD_ADDR_LEN, M_RD_ADDR_BURST, M_RD_ADDR_VALID,
      input  M_RD_ADDR_READY,
      input  M_RD_BACK_ID, M_RD_DATA, M_RD_DATA_RESP, M_RD_DATA_LAST, M_RD_DATA_VALID,
      output M_RD_DATA_READY
   );

   modport slave (
      input  M_WR_ADDR_ID, M_WR_ADDR, M_WR_ADDR_LEN, M_WR_ADDR_BURST, M_WR_ADDR_VALID,
      output M_WR_ADDR_READY,
      input  M_WR_DATA, M_WR_STRB, M_WR_DATA_LAST, M_WR_DATA_VALID,
      output M_WR_DATA_READY,
      output M_WR_BACK_ID, M_WR_BACK_RESP, M_WR_BACK_VALID,
      input  M_WR_BACK_READY,
      input  M_RD_ADDR_ID, M_RD_ADDR, M_RD_ADDR_LEN, M_RD_ADDR_BURST, M_RD_ADDR_VALID,
      output M_RD_ADDR_READY,
      output M_RD_BACK_ID, M_RD_DATA, M_RD_DATA_RESP, M_RD_DATA_LAST, M_RD_DATA_VALID,
      input  M_RD_DATA_READY
   );
endinterface

// File: rtl/ddr_axi_pattern_master.sv
// Burst pattern master: writes NUM_BURSTS INCR bursts of (addr ^ SEED), reads them back
// and counts failing beats/responses.
module ddr_axi_pattern_master #(
   parameter logic [3:0]  ID         = 4'h0,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter logic [7:0]  BURST_LEN  = 8'd15,
   parameter int unsigned NUM_BURSTS = 16,
   parameter logic [31:0] SEED       = 32'hA5A5_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] err_count,
   ddr_axi_pattern_master_if.master m
);
   localparam int unsigned CNT_W = 16;
   localparam logic [31:0] STRIDE = (32'(BURST_LEN) + 32'd1) << 2;
   localparam logic [CNT_W-1:0] LAST_BURST = CNT_W'(NUM_BURSTS - 1);

   typedef enum logic [2:0] {S_IDLE, S_WA, S_WD, S_WB, S_RA, S_RD, S_FIN} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] burst_q, burst_d;
   logic [7:0]       beat_q, beat_d;
   logic [31:0]      burst_addr_q, burst_addr_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             wlast_q, wlast_d;
   logic             awvalid_q, awvalid_d;
   logic             wvalid_q, wvalid_d;
   logic             bready_q, bready_d;
   logic             arvalid_q, arvalid_d;
   logic             rready_q, rready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic [15:0]      err_count_q, err_count_d;

   logic             err_clr;
   logic [1:0]       err_inc;
   logic             beat_last;
   logic             rd_bad;
   logic [31:0]      addr_nxt;
   logic [16:0]      err_sum;

   // next-state and next-output decode
   always_comb begin
      state_d      = state_q;
      burst_d      = burst_q;
      beat_d       = beat_q;
      burst_addr_d = burst_addr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wlast_d      = wlast_q;
      awvalid_d    = awvalid_q;
      wvalid_d     = wvalid_q;
      bready_d     = bready_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      err_clr      = 1'b0;
      err_inc      = 2'd0;
      beat_last    = (beat_q == BURST_LEN);
      addr_nxt     = addr_q + 32'd4;
      rd_bad       = (m.M_RD_DATA != (addr_q ^ SEED)) || (m.M_RD_DATA_RESP != 2'b00) ||
                     (m.M_RD_BACK_ID != ID);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_WA;
               busy_d       = 1'b1;
               err_clr      = 1'b1;
               burst_d      = '0;
               burst_addr_d = BASE_ADDR;
               awvalid_d    = 1'b1;
            end
         end
         S_WA: begin
            if (m.M_WR_ADDR_READY) begin
               state_d   = S_WD;
               awvalid_d = 1'b0;
               beat_d    = 8'd0;
               addr_d    = burst_addr_q;
               wdata_d   = burst_addr_q ^ SEED;
               wlast_d   = (BURST_LEN == 8'd0);
               wvalid_d  = 1'b1;
            end
         end
         S_WD: begin
            if (m.M_WR_DATA_READY) begin
               if (beat_last) begin
                  state_d  = S_WB;
                  wvalid_d = 1'b0;
                  wlast_d  = 1'b0;
                  bready_d = 1'b1;
               end else begin
                  beat_d  = beat_q + 8'd1;
                  addr_d  = addr_nxt;
                  wdata_d = addr_nxt ^ SEED;
                  wlast_d = ((beat_q + 8'd1) == BURST_LEN);
               end
            end
         end
         S_WB: begin
            if (m.M_WR_BACK_VALID) begin
               bready_d = 1'b0;
               err_inc  = {1'b0, (m.M_WR_BACK_RESP != 2'b00) || (m.M_WR_BACK_ID != ID)};
               if (burst_q == LAST_BURST) begin
                  state_d      = S_RA;
                  burst_d      = '0;
                  burst_addr_d = BASE_ADDR;
                  arvalid_d    = 1'b1;
               end else begin
                  state_d      = S_WA;
                  burst_d      = burst_q + 16'd1;
                  burst_addr_d = burst_addr_q + STRIDE;
                  awvalid_d    = 1'b1;
               end
            end
         end
         S_RA: begin
            if (m.M_RD_ADDR_READY) begin
               state_d   = S_RD;
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               beat_d    = 8'd0;
               addr_d    = burst_addr_q;
            end
         end
         S_RD: begin
            if (m.M_RD_DATA_VALID) begin
               // data/resp/id faults count once per beat; a misplaced LAST counts separately
               err_inc = {1'b0, rd_bad} + {1'b0, m.M_RD_DATA_LAST != beat_last};
               if (beat_last) begin
                  rready_d = 1'b0;
                  if (burst_q == LAST_BURST) begin
                     state_d = S_FIN;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                  end else begin
                     state_d      = S_RA;
                     burst_d      = burst_q + 16'd1;
                     burst_addr_d = burst_addr_q + STRIDE;
                     arvalid_d    = 1'b1;
                  end
               end else begin
                  beat_d = beat_q + 8'd1;
                  addr_d = addr_nxt;
               end
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      err_sum     = (err_clr ? 17'd0 : 17'(err_count_q)) + 17'(err_inc);
      err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
      error_d     = (err_clr ? 1'b0 : error_q) | (err_inc != 2'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         burst_q      <= '0;
         beat_q       <= 8'd0;
         burst_addr_q <= 32'd0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         wlast_q      <= 1'b0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         err_count_q  <= 16'd0;
      end else begin
         state_q      <= state_d;
         burst_q      <= burst_d;
         beat_q       <= beat_d;
         burst_addr_q <= burst_addr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wlast_q      <= wlast_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         bready_q     <= bready_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
         err_count_q  <= err_count_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign err_count = err_count_q;

   // the active burst address is held stable for whichever address channel is valid
   assign m.M_WR_ADDR_ID    = ID;
   assign m.M_WR_ADDR       = burst_addr_q;
   assign m.M_WR_ADDR_LEN   = BURST_LEN;
   assign m.M_WR_ADDR_BURST = 2'b01;
   assign m.M_WR_ADDR_VALID = awvalid_q;
   assign m.M_WR_DATA       = wdata_q;
   assign m.M_WR_STRB       = 4'hF;
   assign m.M_WR_DATA_LAST  = wlast_q;
   assign m.M_WR_DATA_VALID = wvalid_q;
   assign m.M_WR_BACK_READY = bready_q;
   assign m.M_RD_ADDR_ID    = ID;
   assign m.M_RD_ADDR       = burst_addr_q;
   assign m.M_RD_ADDR_LEN   = BURST_LEN;
   assign m.M_RD_ADDR_BURST = 2'b01;
   assign m.M_RD_ADDR_VALID = arvalid_q;
   assign m.M_RD_DATA_READY = rready_q;
endmodule
